// File: rtl/button_debounce_if.sv
// Button debounce signal bundle: synchronized raw level in, debounced level and
// event pulses out.
interface button_debounce_if;
  logic signal_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  modport master (
    output signal_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  signal_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/button_debounce.sv
// Debounces a synchronized button level with a confirm counter and emits
// registered level, press, release and long-press pulses.
module button_debounce #(
  parameter int FILTER_CNT = 20000,
  parameter int LONG_CNT   = 50000000
) (
  input  logic           clk_dst,
  input  logic           rst_dst,
  button_debounce_if.slave bus
);

  localparam int FILT_W = $clog2(FILTER_CNT);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CNT - 1);
  localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CNT);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [FILT_W-1:0]   filt_cnt_r, filt_nxt_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_nxt_s;
  logic                level_r, level_nxt_s;
  logic                press_r, press_nxt_s;
  logic                release_r, release_nxt_s;
  logic                long_r, long_nxt_s;

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk_dst or posedge rst_dst) begin
    if (rst_dst) begin
      state_r    <= IDLE;
      filt_cnt_r <= '0;
      hold_cnt_r <= '0;
      level_r    <= 1'b0;
      press_r    <= 1'b0;
      release_r  <= 1'b0;
      long_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      filt_cnt_r <= filt_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      level_r    <= level_nxt_s;
      press_r    <= press_nxt_s;
      release_r  <= release_nxt_s;
      long_r     <= long_nxt_s;
    end
  end

  // Next-state, counter and output decode; pulses default low every cycle.
  always_comb begin
    state_nxt_s   = state_r;
    filt_nxt_s    = filt_cnt_r;
    hold_nxt_s    = hold_cnt_r;
    level_nxt_s   = level_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.signal_in) begin
          state_nxt_s = PRESS_WAIT;
          filt_nxt_s  = FILT_ONE;
        end else begin
          filt_nxt_s  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!bus.signal_in) begin
          state_nxt_s = IDLE;
          filt_nxt_s  = '0;
        end else if (filt_cnt_r == FILT_LAST) begin
          state_nxt_s = PRESSED;
          filt_nxt_s  = '0;
          hold_nxt_s  = '0;
          level_nxt_s = 1'b1;
          press_nxt_s = 1'b1;
        end else begin
          filt_nxt_s  = filt_cnt_r + FILT_ONE;
        end
      end
      PRESSED: begin
        // hold_cnt saturates at LONG_CNT, so the long pulse can only fire once per press.
        if (bus.signal_in) begin
          if (hold_cnt_r != HOLD_MAX) begin
            hold_nxt_s = hold_cnt_r + HOLD_ONE;
            long_nxt_s = (hold_cnt_r == (HOLD_MAX - HOLD_ONE));
          end else begin
            hold_nxt_s = hold_cnt_r;
          end
        end else begin
          state_nxt_s = RELEASE_WAIT;
          filt_nxt_s  = FILT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (bus.signal_in) begin
          state_nxt_s = PRESSED;
          filt_nxt_s  = '0;
        end else if (filt_cnt_r == FILT_LAST) begin
          state_nxt_s   = IDLE;
          filt_nxt_s    = '0;
          hold_nxt_s    = '0;
          level_nxt_s   = 1'b0;
          release_nxt_s = 1'b1;
        end else begin
          filt_nxt_s    = filt_cnt_r + FILT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        filt_nxt_s  = '0;
        hold_nxt_s  = '0;
        level_nxt_s = 1'b0;
      end
    endcase
  end

  assign bus.btn_level   = level_r;
  assign bus.btn_press   = press_r;
  assign bus.btn_release = release_r;
  assign bus.btn_long    = long_r;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce (FILTER_CNT=4, LONG_CNT=10): fixed vector table,
// hand sequences for short press and async reset, then random runs vs a model.
module tb_button_debounce;

  localparam int FILTER_CNT = 4;
  localparam int LONG_CNT   = 10;

  typedef struct {
    logic in;
    logic level;
    logic press;
    logic rel;
    logic lng;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  button_debounce_if bif ();

  button_debounce #(.FILTER_CNT(FILTER_CNT), .LONG_CNT(LONG_CNT)) dut (
    .clk_dst (clk),
    .rst_dst (rst),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  vec_t vecs[$];

  // Reference model: debounced level, count of consecutive disagreeing
  // samples, and cycles held since the press.
  logic m_level, m_press, m_rel, m_long;
  int   m_run, m_held;

  function automatic void add(input logic in, input logic l, input logic p,
                              input logic r, input logic g);
    vec_t v;
    v.in = in; v.level = l; v.press = p; v.rel = r; v.lng = g;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    m_run = 0; m_held = 0;
  endfunction

  function automatic void model_edge(input logic v);
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    if (v != m_level) begin
      m_run++;
      if (m_run == FILTER_CNT) begin
        m_level = v;
        m_press = v;
        m_rel   = !v;
        m_run   = 0;
        m_held  = 0;
      end
    end else begin
      if (m_level && m_run == 0 && m_held < LONG_CNT) begin
        m_held++;
        if (m_held == LONG_CNT) m_long = 1'b1;
      end
      m_run = 0;
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".level"},   bif.btn_level,   m_level);
    chk({tag, ".press"},   bif.btn_press,   m_press);
    chk({tag, ".release"}, bif.btn_release, m_rel);
    chk({tag, ".long"},    bif.btn_long,    m_long);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".level"},   bif.btn_level,   1'b0);
    chk({tag, ".press"},   bif.btn_press,   1'b0);
    chk({tag, ".release"}, bif.btn_release, 1'b0);
    chk({tag, ".long"},    bif.btn_long,    1'b0);
  endtask

  // Drive one sample, let one edge take it, check outputs on the falling edge.
  task automatic step(input logic v);
    bif.signal_in = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk_zero(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Bounce on press, long hold, release bounce: explicit expected outputs.
    add(1'b1, 0, 0, 0, 0); add(1'b1, 0, 0, 0, 0); add(1'b1, 0, 0, 0, 0);
    add(1'b0, 0, 0, 0, 0);
    add(1'b1, 0, 0, 0, 0); add(1'b1, 0, 0, 0, 0); add(1'b1, 0, 0, 0, 0);
    add(1'b1, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) add(1'b1, 1, 0, 0, 0);
    add(1'b1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(1'b1, 1, 0, 0, 0);
    add(1'b0, 1, 0, 0, 0); add(1'b0, 1, 0, 0, 0);
    add(1'b1, 1, 0, 0, 0); add(1'b1, 1, 0, 0, 0);
    add(1'b0, 1, 0, 0, 0); add(1'b0, 1, 0, 0, 0); add(1'b0, 1, 0, 0, 0);
    add(1'b0, 0, 0, 1, 0);
    add(1'b0, 0, 0, 0, 0); add(1'b0, 0, 0, 0, 0);

    bif.signal_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    #2;
    rst = 1'b0;

    foreach (vecs[i]) begin
      bif.signal_in = vecs[i].in;
      @(posedge clk);
      model_edge(vecs[i].in);
      @(negedge clk);
      chk($sformatf("vec%0d.level", i),   bif.btn_level,   vecs[i].level);
      chk($sformatf("vec%0d.press", i),   bif.btn_press,   vecs[i].press);
      chk($sformatf("vec%0d.release", i), bif.btn_release, vecs[i].rel);
      chk($sformatf("vec%0d.long", i),    bif.btn_long,    vecs[i].lng);
    end

    // Short press: six high samples, release 4 edges after the first low.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1);
      chk($sformatf("short.press%0d", i), bif.btn_press, (i == 4));
      chk("short.nolong", bif.btn_long, 1'b0);
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b0);
      chk($sformatf("short.release%0d", i), bif.btn_release, (i == 4));
      chk($sformatf("short.level%0d", i), bif.btn_level, (i < 4));
      chk("short.nolong", bif.btn_long, 1'b0);
    end

    // Async reset while PRESSED, input still high afterwards.
    repeat (6) step(1'b1);
    chk("pre_rst.level", bif.btn_level, 1'b1);
    async_reset("rst_mid");
    for (int i = 1; i <= 5; i++) begin
      step(1'b1);
      chk($sformatf("post_rst.press%0d", i), bif.btn_press, (i == 4));
      chk($sformatf("post_rst.level%0d", i), bif.btn_level, (i >= 4));
      chk("post_rst.norelease", bif.btn_release, 1'b0);
    end

    // Random runs of each level, with occasional long holds and resets.
    begin
      logic lvl;
      int   len;
      lvl = 1'b0;
      for (int r = 0; r < 150; r++) begin
        lvl = ~lvl;
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 18)
                                           : $urandom_range(1, 6);
        for (int k = 0; k < len; k++) begin
          step(lvl);
          chk_model("rand");
        end
        if ($urandom_range(0, 39) == 0) async_reset("rand_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
